// File: rtl/smvm_pkg.sv
// Shared definitions for the SpMV front-end: state encoding, default geometry
// and field widths.
package smvm_pkg;

  localparam int K_DEF         = 4;
  localparam int VEC_DEPTH_DEF = 128;
  localparam int PIPE_LAT_DEF  = 4;

  localparam int VAL_W = 8;
  localparam int COL_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_COL,
    ST_VEC,
    ST_VAL,
    ST_IDX,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/smvm_vec_buf.sv
// Dense-vector buffer: VEC_DEPTH x VAL_W register file, one write port and K
// combinational read ports. A read whose column is at or beyond the current
// column count (or beyond the buffer depth) returns zero. Lane 0 is packed in
// the most significant slot of rd_col / rd_data.
module smvm_vec_buf
  import smvm_pkg::*;
#(
  parameter int K         = K_DEF,
  parameter int VEC_DEPTH = VEC_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [COL_W-1:0]     wr_addr,
  input  logic [VAL_W-1:0]     wr_data,
  input  logic [COL_W-1:0]     cols,
  input  logic [K*COL_W-1:0]   rd_col,
  output logic [K*VAL_W-1:0]   rd_data
);

  localparam int AW = (VEC_DEPTH > 1) ? $clog2(VEC_DEPTH) : 1;

  logic [VAL_W-1:0] mem [VEC_DEPTH];

  // Write port; addresses past the buffer depth are silently dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < VEC_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && (int'(wr_addr) < VEC_DEPTH)) begin
      mem[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  // K bounded read ports.
  always_comb begin
    rd_data = '0;
    for (int l = 0; l < K; l++) begin
      if ((rd_col[(K-1-l)*COL_W +: COL_W] < cols) &&
          (int'(rd_col[(K-1-l)*COL_W +: COL_W]) < VEC_DEPTH)) begin
        rd_data[(K-1-l)*VAL_W +: VAL_W] = mem[rd_col[(K-1-l)*COL_W +: AW]];
      end
    end
  end

endmodule

// File: rtl/smvm_batch_scheduler.sv
// SpMV front-end sequencer: parses header / vector / (value, index) stream,
// groups entries into K-lane batches, issues them over valid/ready and pulses
// done once the ALU pipeline has drained.
// Optional: define SMVM_SCHED_PERF_EN to add the stall_cycles counter port.
module smvm_batch_scheduler
  import smvm_pkg::*;
#(
  parameter int K         = K_DEF,
  parameter int VEC_DEPTH = VEC_DEPTH_DEF,
  parameter int PIPE_LAT  = PIPE_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [VAL_W-1:0]     val_in,
  input  logic [2:0]           col_in,
  input  logic                 ipv_in,
  output logic                 in_ready,
  output logic                 batch_valid,
  input  logic                 batch_ready,
  output logic [K*VAL_W-1:0]   batch_val,
  output logic [K*VAL_W-1:0]   batch_vec,
  output logic [K-1:0]         batch_ipv,
  output logic                 batch_last,
  output logic [7:0]           rows_done,
  output logic                 done
`ifdef SMVM_SCHED_PERF_EN
  ,
  output logic [15:0]          stall_cycles
`endif
);

  localparam int ECW = (K > 1) ? $clog2(K) : 1;
  localparam int DW  = $clog2(PIPE_LAT + 1);

  state_t                  state;
  logic [COL_W-1:0]        cols;
  logic [COL_W-1:0]        vcnt;
  logic [ECW-1:0]          ecnt;
  logic [DW-1:0]           dcnt;
  logic signed [VAL_W-1:0] val_r [K];
  logic [K-1:0]            ipv_r;
  logic [COL_W-1:0]        col_r [K];

  logic [COL_W-1:0]        col_idx;
  logic                    vec_wr;
  logic [K*COL_W-1:0]      rd_col;
  logic [K*VAL_W-1:0]      rd_data;
  logic [K-1:0]            nxt_live;
  logic [K*VAL_W-1:0]      nxt_val;
  logic [K*VAL_W-1:0]      nxt_vec;
  logic [K-1:0]            nxt_ipv;

  // Rows-done accumulation: add the row-end flags of a batch, clamp at 255.
  function automatic logic [7:0] sat_rows(input logic [7:0] cur, input logic [K-1:0] flags);
    logic [8:0] sum;
    sum = {1'b0, cur};
    for (int i = 0; i < K; i++) sum = sum + {8'd0, flags[i]};
    return (sum > 9'd255) ? 8'hFF : sum[7:0];
  endfunction

  // Index beats carry an 8-bit column spread over val_in[3:0], ipv_in, col_in.
  // The header row count is consumed but not kept: row ends travel as ipv flags.
  assign col_idx  = {val_in[3:0], ipv_in, col_in};
  assign in_ready = state inside {ST_IDLE, ST_HDR_COL, ST_VEC, ST_VAL, ST_IDX};
  assign vec_wr   = (state == ST_VEC) && in_valid;

  smvm_vec_buf #(
    .K         (K),
    .VEC_DEPTH (VEC_DEPTH)
  ) u_vec_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (vec_wr),
    .wr_addr (vcnt),
    .wr_data (val_in),
    .cols    (cols),
    .rd_col  (rd_col),
    .rd_data (rd_data)
  );

  // Next batch: the lane being indexed this cycle takes its column straight
  // from the input so the batch can launch without an extra cycle; lanes not
  // yet filled at end of matrix are masked to zero.
  always_comb begin
    rd_col   = '0;
    nxt_val  = '0;
    nxt_ipv  = '0;
    nxt_live = '0;
    for (int l = 0; l < K; l++) begin
      rd_col[(K-1-l)*COL_W +: COL_W] =
        ((state == ST_IDX) && (l == int'(ecnt))) ? col_idx : col_r[l];
      if ((l < int'(ecnt)) || ((state == ST_IDX) && (l == int'(ecnt)))) begin
        nxt_live[K-1-l]                 = 1'b1;
        nxt_val[(K-1-l)*VAL_W +: VAL_W] = val_r[l];
        nxt_ipv[K-1-l]                  = ipv_r[l];
      end
    end
  end

  // Vector operands of live lanes only.
  always_comb begin
    nxt_vec = '0;
    for (int l = 0; l < K; l++) begin
      if (nxt_live[l]) nxt_vec[l*VAL_W +: VAL_W] = rd_data[l*VAL_W +: VAL_W];
    end
  end

  // Main sequencer with registered batch and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cols        <= '0;
      vcnt        <= '0;
      ecnt        <= '0;
      dcnt        <= '0;
      ipv_r       <= '0;
      for (int l = 0; l < K; l++) begin
        val_r[l] <= '0;
        col_r[l] <= '0;
      end
      batch_valid <= 1'b0;
      batch_val   <= '0;
      batch_vec   <= '0;
      batch_ipv   <= '0;
      batch_last  <= 1'b0;
      rows_done   <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (in_valid) begin
          rows_done <= '0;
          state     <= ST_HDR_COL;
        end
        ST_HDR_COL: if (in_valid) begin
          cols  <= col_idx;
          vcnt  <= '0;
          state <= (col_idx == '0) ? ST_VAL : ST_VEC;
        end
        ST_VEC: if (in_valid) begin
          vcnt <= vcnt + 8'd1;
          if (vcnt == cols - 8'd1) state <= ST_VAL;
        end
        ST_VAL: if (in_valid) begin
          val_r[ecnt] <= val_in;
          ipv_r[ecnt] <= ipv_in;
          state       <= ST_IDX;
        end else begin
          batch_val   <= nxt_val;
          batch_vec   <= nxt_vec;
          batch_ipv   <= nxt_ipv;
          batch_last  <= 1'b1;
          batch_valid <= 1'b1;
          ecnt        <= '0;
          state       <= ST_ISSUE;
        end
        ST_IDX: if (in_valid) begin
          col_r[ecnt] <= col_idx;
          if (int'(ecnt) == K - 1) begin
            batch_val   <= nxt_val;
            batch_vec   <= nxt_vec;
            batch_ipv   <= nxt_ipv;
            batch_last  <= 1'b0;
            batch_valid <= 1'b1;
            ecnt        <= '0;
            state       <= ST_ISSUE;
          end else begin
            ecnt  <= ecnt + 1'b1;
            state <= ST_VAL;
          end
        end
        ST_ISSUE: if (batch_ready) begin
          batch_valid <= 1'b0;
          rows_done   <= sat_rows(rows_done, batch_ipv);
          dcnt        <= '0;
          state       <= batch_last ? ST_DRAIN : ST_VAL;
        end
        ST_DRAIN: begin
          if (int'(dcnt) == PIPE_LAT - 1) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SMVM_SCHED_PERF_EN
  // Saturating count of cycles a batch waits on the ALU; cleared per matrix.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if ((state == ST_IDLE) && in_valid) begin
      stall_cycles <= '0;
    end else if (batch_valid && !batch_ready && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_smvm_batch_scheduler.sv
// Directed bench for smvm_batch_scheduler (K=4, PIPE_LAT=4, VEC_DEPTH=128).
module tb_smvm_batch_scheduler;

  localparam int K        = 4;
  localparam int PIPE_LAT = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  val_in;
  logic [2:0]  col_in;
  logic        ipv_in;
  logic        in_ready;
  logic        batch_valid;
  logic        batch_ready;
  logic [31:0] batch_val;
  logic [31:0] batch_vec;
  logic [3:0]  batch_ipv;
  logic        batch_last;
  logic [7:0]  rows_done;
  logic        done;
`ifdef SMVM_SCHED_PERF_EN
  logic [15:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  smvm_batch_scheduler #(.K(K), .VEC_DEPTH(128), .PIPE_LAT(PIPE_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .val_in      (val_in),
    .col_in      (col_in),
    .ipv_in      (ipv_in),
    .in_ready    (in_ready),
    .batch_valid (batch_valid),
    .batch_ready (batch_ready),
    .batch_val   (batch_val),
    .batch_vec   (batch_vec),
    .batch_ipv   (batch_ipv),
    .batch_last  (batch_last),
    .rows_done   (rows_done),
    .done        (done)
`ifdef SMVM_SCHED_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat at a negedge, hold it across one rising edge, return at
  // the next negedge with in_valid low (the next call may re-raise it at once).
  task automatic send(input logic [7:0] v, input logic ipv, input logic [2:0] c);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    val_in   = v;
    ipv_in   = ipv;
    col_in   = c;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_idx(input logic [7:0] c);
    send({4'd0, c[7:4]}, c[3], c[2:0]);
  endtask

  task automatic header(input logic [7:0] rows, input logic [7:0] cols);
    send_idx(rows);
    send_idx(cols);
  endtask

  task automatic entry(input logic [7:0] v, input logic ipv, input logic [7:0] c);
    send(v, ipv, 3'd0);
    send_idx(c);
  endtask

  // Wait for a batch, accept it; returns at the negedge after the handshake edge.
  task automatic take_batch();
    int n = 0;
    while (!batch_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!batch_valid) check("batch_timeout", {31'd0, batch_valid}, 32'd1);
    batch_ready = 1'b1;
    @(negedge clk);
    batch_ready = 1'b0;
  endtask

  // Called in the first cycle after the last-batch handshake (cycle 1);
  // done must be high in cycle PIPE_LAT+1 and for exactly one cycle.
  task automatic wait_done();
    int n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_latency", n, PIPE_LAT + 1);
    check("done_high", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);
    check("idle_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    val_in      = '0;
    col_in      = '0;
    ipv_in      = 1'b0;
    batch_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_valid", {31'd0, batch_valid}, 32'd0);
    check("rst_val", batch_val, 32'd0);
    check("rst_vec", batch_vec, 32'd0);
    check("rst_ipv", {28'd0, batch_ipv}, 32'd0);
    check("rst_last", {31'd0, batch_last}, 32'd0);
    check("rst_rows", {24'd0, rows_done}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
`ifdef SMVM_SCHED_PERF_EN
    check("rst_stall", {16'd0, stall_cycles}, 32'd0);
`endif

    // batch_ready with no batch pending does nothing
    batch_ready = 1'b1;
    repeat (2) @(negedge clk);
    batch_ready = 1'b0;
    check("idle_ready_nop_valid", {31'd0, batch_valid}, 32'd0);
    check("idle_ready_nop_rows", {24'd0, rows_done}, 32'd0);

    // Full batch: rows=2 cols=4 vec={1,2,3,4}
    header(8'd2, 8'd4);
    send(8'd1, 1'b0, 3'd0);
    send(8'd2, 1'b0, 3'd0);
    send(8'd3, 1'b0, 3'd0);
    send(8'd4, 1'b0, 3'd0);
    entry(8'd5, 1'b0, 8'd0);
    entry(8'd6, 1'b1, 8'd1);
    entry(8'd7, 1'b0, 8'd2);
    entry(8'd8, 1'b1, 8'd3);
    check("full_valid", {31'd0, batch_valid}, 32'd1);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_val", batch_val, 32'h05060708);
    check("full_vec", batch_vec, 32'h01020304);
    check("full_ipv", {28'd0, batch_ipv}, 32'b0101);
    check("full_last", {31'd0, batch_last}, 32'd0);
    take_batch();
    check("full_rows", {24'd0, rows_done}, 32'd2);
    check("full_valid_drop", {31'd0, batch_valid}, 32'd0);
    @(negedge clk);
    check("zero_valid", {31'd0, batch_valid}, 32'd1);
    check("zero_val", batch_val, 32'd0);
    check("zero_vec", batch_vec, 32'd0);
    check("zero_ipv", {28'd0, batch_ipv}, 32'd0);
    check("zero_last", {31'd0, batch_last}, 32'd1);
    take_batch();
    wait_done();
    check("full_rows_end", {24'd0, rows_done}, 32'd2);

    // Partial batch: cols=2 vec={10,20}, entries (3,c1,0),(-2,c0,1)
    header(8'd1, 8'd2);
    send(8'd10, 1'b0, 3'd0);
    send(8'd20, 1'b0, 3'd0);
    entry(8'd3, 1'b0, 8'd1);
    entry(8'hFE, 1'b1, 8'd0);
    check("part_not_yet", {31'd0, batch_valid}, 32'd0);
    @(negedge clk);
    check("part_valid", {31'd0, batch_valid}, 32'd1);
    check("part_val", batch_val, 32'h03FE0000);
    check("part_vec", batch_vec, 32'h140A0000);
    check("part_ipv", {28'd0, batch_ipv}, 32'b0100);
    check("part_last", {31'd0, batch_last}, 32'd1);
    take_batch();
    check("part_rows", {24'd0, rows_done}, 32'd1);
    wait_done();

    // cols=0 plus 5 cycles of backpressure; vec[3]=4 persists but is out of range
    header(8'd1, 8'd0);
    entry(8'd9, 1'b1, 8'd3);
    @(negedge clk);
    check("c0_valid", {31'd0, batch_valid}, 32'd1);
    check("c0_val", batch_val, 32'h09000000);
    check("c0_vec", batch_vec, 32'd0);
    check("c0_ipv", {28'd0, batch_ipv}, 32'b1000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, batch_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_val", batch_val, 32'h09000000);
      check("bp_ipv", {28'd0, batch_ipv}, 32'b1000);
      check("bp_last", {31'd0, batch_last}, 32'd1);
    end
`ifdef SMVM_SCHED_PERF_EN
    check("bp_stall", {16'd0, stall_cycles}, 32'd5);
`endif
    take_batch();
    check("bp_rows", {24'd0, rows_done}, 32'd1);
    wait_done();

    // Out-of-range columns: cols=2 vec={30,40}; columns 5 and 2 read as zero
    header(8'd1, 8'd2);
    send(8'd30, 1'b0, 3'd0);
    send(8'd40, 1'b0, 3'd0);
    entry(8'd1, 1'b0, 8'd5);
    entry(8'd2, 1'b0, 8'd1);
    entry(8'd3, 1'b1, 8'd2);
    entry(8'd4, 1'b0, 8'd0);
    check("oor_val", batch_val, 32'h01020304);
    check("oor_vec", batch_vec, 32'h0028001E);
    check("oor_ipv", {28'd0, batch_ipv}, 32'b0010);
    take_batch();
    take_batch();
    check("oor_end_last", {31'd0, batch_last}, 32'd1);
    wait_done();
    check("oor_rows", {24'd0, rows_done}, 32'd1);

    // rows_done saturation: 65 full batches of row-end lanes
    header(8'd0, 8'd0);
    for (int b = 0; b < 65; b++) begin
      for (int e = 0; e < K; e++) entry(8'(b + 1), 1'b1, 8'd0);
      take_batch();
      if (b == 62) check("sat_rows_252", {24'd0, rows_done}, 32'd252);
    end
    check("sat_rows_255", {24'd0, rows_done}, 32'd255);
    take_batch();
    wait_done();

    // Reset while a batch is pending
    header(8'd0, 8'd0);
    entry(8'd7, 1'b1, 8'd0);
    @(negedge clk);
    check("mid_valid", {31'd0, batch_valid}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_valid", {31'd0, batch_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_rows", {24'd0, rows_done}, 32'd0);
    check("mid_rst_val", batch_val, 32'd0);
    header(8'd1, 8'd1);
    send(8'd50, 1'b0, 3'd0);
    entry(8'd6, 1'b1, 8'd0);
    @(negedge clk);
    check("fresh_valid", {31'd0, batch_valid}, 32'd1);
    check("fresh_val", batch_val, 32'h06000000);
    check("fresh_vec", batch_vec, 32'h32000000);
    check("fresh_ipv", {28'd0, batch_ipv}, 32'b1000);
    check("fresh_last", {31'd0, batch_last}, 32'd1);
    take_batch();
    check("fresh_rows", {24'd0, rows_done}, 32'd1);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/smvm_batch_scheduler.md
# smvm_batch_scheduler

Front-end sequencer for the sparse matrix–vector multiply engine.
- Parses the serial input stream: row/column header, dense vector, then (value, ipv, column) matrix entries.
- Buffers the vector and groups matrix entries into K-wide batches.
- Issues each batch to the ALU tree over a valid/ready handshake, holding off the input stream while a batch is pending.
- Signals completion once the ALU pipeline has drained.

## Interface
- K, 4, lanes per batch
- VEC_DEPTH, 128, vector buffer entries
- PIPE_LAT, 4, ALU pipeline latency in cycles (drain wait after last batch)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input beat valid
- val_in  in  8  signed value / header byte
- col_in  in  3  low column-index bits
- ipv_in  in  1  row-end flag (value beat), index bit 3 (index beat)
- in_ready  out  1  beat accepted when in_valid & in_ready
- batch_valid  out  1  batch offered to ALU
- batch_ready  in  1  ALU accepts batch
- batch_val  out  8K  lane values, lane 0 in MSBs
- batch_vec  out  8K  vector operands vec[col[lane]], lane 0 in MSBs
- batch_ipv  out  K  row-end flags, lane 0 in MSB
- batch_last  out  1  final batch of the matrix
- rows_done  out  8  ipv=1 lanes issued since header, saturating at 255
- done  out  1  one-cycle pulse after drain

## Operation
**Field definition:** col_idx = {val_in, ipv_in, col_in}[7:0]. Vector address uses col_idx[6:0].

**States:** IDLE, HDR_COL, VEC, VAL, IDX, ISSUE, DRAIN, DONE.

**State transitions:**
- IDLE: on accepted beat, rows <= col_idx, rows_done <= 0 -> HDR_COL.
- HDR_COL: on accepted beat, cols <= col_idx, vcnt <= 0.
  - cols==0 -> VAL.
  - Otherwise -> VEC.
- VEC: each accepted beat writes vec[vcnt] <= val_in.
  - vcnt==cols-1 -> VAL.
  - cols > VEC_DEPTH: writes with vcnt >= VEC_DEPTH are dropped.
- VAL:
  - in_valid=1: val[ecnt] <= val_in, ipv[ecnt] <= ipv_in -> IDX.
  - in_valid=0 for one cycle: end of matrix -> ISSUE with last=1.
  - Partial batch at end: lanes ecnt..K-1 are padded with val=0, vec=0, ipv=0.
  - ecnt==0 at end: an all-zero batch is issued with batch_last=1.
- IDX: in_valid=0 holds the state.
  - Accepted beat: col[ecnt] <= col_idx.
  - ecnt==K-1 -> ISSUE with last=0, ecnt <= 0.
  - Otherwise ecnt++ -> VAL.
- ISSUE: batch_valid=1, outputs held stable until batch_ready.
  - On handshake, rows_done += popcount(batch_ipv), saturating.
  - last=0 -> VAL.
  - last=1 -> DRAIN.
- DRAIN: count PIPE_LAT cycles -> DONE.
- DONE: done=1 for one cycle -> IDLE.

**Data rules:**
- in_ready=1 in IDLE, HDR_COL, VEC, VAL, IDX; 0 in ISSUE, DRAIN, DONE.
- Beats presented while in_ready=0 are ignored; the source holds them.
- Vector lookup: col >= cols or col >= VEC_DEPTH returns 0.
- Vector buffer contents persist across matrices; only entries rewritten in VEC change.

## Timing
- batch_valid rises the cycle after the index beat of the K-th entry is accepted, or the cycle after the end-of-matrix idle cycle.
- batch_* outputs are registered.
- Back-to-back entries: 2 input cycles per entry, plus at least 1 ISSUE cycle per batch.
- done asserts exactly PIPE_LAT+1 cycles after the last-batch handshake.
- Reset values:
  - State: IDLE.
  - in_ready=1.
  - Registered outputs: batch_valid=0, batch_val=0, batch_vec=0, batch_ipv=0, batch_last=0, rows_done=0, done=0.
  - Counters, vector buffer and internal lane registers: 0.
- Reset mid-operation aborts the current matrix:
  - Any pending batch is dropped with no handshake.
  - batch_valid is low the cycle after reset.
- batch_ready while batch_valid=0 has no effect.

## Configuration
- SMVM_SCHED_PERF_EN defined: adds output port stall_cycles (16 bits).
  - Counts cycles with batch_valid & !batch_ready.
  - Saturates at 0xFFFF.
  - Cleared on the header beat accepted in IDLE.
  - Reset value 0.
- Not defined: port and counter are absent; all other behaviour is identical.

## Structure
- Shared package smvm_pkg holds:
  - State encoding.
  - Default K, VEC_DEPTH, PIPE_LAT.
  - Width constants VAL_W=8 and COL_W=8.
- Sub-module smvm_vec_buf: VEC_DEPTH×8 register file with one write port and K combinational read ports.
  - Out-of-range reads return 0; the bound is the cols input.

## Test plan
- **Full batch:** rows=2, cols=4, vec={1,2,3,4}, entries (5,c0,ipv0),(6,c1,ipv1),(7,c2,ipv0),(8,c3,ipv1), then end.
  - Expect batch val={5,6,7,8}, vec={1,2,3,4}, ipv=0101, last=0.
  - Expect a zero batch with last=1.
  - Expect rows_done=2 and done PIPE_LAT+1 cycles after the last handshake.
- **Partial batch:** 2 entries (3,c1,ipv0),(-2,c0,ipv1), then end.
  - Expect a single batch val={3,-2,0,0}, ipv=0100, last=1.
- **Backpressure:** batch_ready held 0 for 5 cycles.
  - Expect batch_* stable and in_ready=0 throughout.
  - With SMVM_SCHED_PERF_EN, expect stall_cycles=5.
- **Out-of-range column:** cols=2, entry column 5.
  - Expect that lane's batch_vec byte = 0.
- **cols=0:** header then entries directly.
  - Expect no VEC phase and all vec operands 0.
- **Reset mid-ISSUE:** rst_n=0 for one cycle while a batch is pending.
  - Expect batch_valid=0, in_ready=1, rows_done=0.
  - Expect a fresh header to be accepted normally.
